// File: rtl/stall_ctrl_pkg.sv
// Shared types and helpers for the pipeline interlock controller:
// memory-handshake FSM states, default timeout and wait-counter sizing.
package stall_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        ERR  = 2'd2
    } stall_state_t;

    localparam int MEM_TIMEOUT_DEFAULT = 64;

    // Wait counter must be able to hold the value MEM_TIMEOUT itself.
    function automatic int cnt_width(input int timeout);
        return $clog2(timeout) + 1;
    endfunction

endpackage

// File: rtl/stall_perf_counters.sv
// Three saturating event counters (load-use, memory stall, IF/ID flush).
// Only instantiated when STALL_PERF_CNT_EN is defined.
module stall_perf_counters
    import stall_ctrl_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [2:0]       evt_i,
    output logic [CNT_W-1:0] loaduse_o,
    output logic [CNT_W-1:0] memstall_o,
    output logic [CNT_W-1:0] flush_o
);

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            logic [CNT_W-1:0] cnt_reg;

            // Count the event each cycle it is present, sticking at all-ones.
            always_ff @(posedge clk_i) begin
                if (!rst_i) begin
                    cnt_reg <= '0;
                end else if (evt_i[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + 1'b1;
                end
            end
        end
    endgenerate

    assign loaduse_o  = g_cnt[0].cnt_reg;
    assign memstall_o = g_cnt[1].cnt_reg;
    assign flush_o    = g_cnt[2].cnt_reg;

endmodule

// File: rtl/pipeline_stall_ctrl.sv
// Pipeline interlock controller for the 5-stage MIPS core. Resolves memory
// freeze, load-use stall and branch flush into per-stage enables/flushes.
// Optional performance counters are built when STALL_PERF_CNT_EN is defined.
module pipeline_stall_ctrl
    import stall_ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = MEM_TIMEOUT_DEFAULT,
    parameter int CNT_W       = 32
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic hazard_stall_i,
    input  logic branch_taken_i,
    input  logic EX_MEM_MemRead_i,
    input  logic EX_MEM_MemWrite_i,
    input  logic mem_ack_i,
    output logic mem_req_o,
    output logic PC_Write_o,
    output logic IF_ID_Write_o,
    output logic IF_ID_Flush_o,
    output logic ID_EX_Flush_o,
    output logic EX_MEM_Write_o,
    output logic MEM_WB_Write_o,
    output logic mem_err_o
`ifdef STALL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0] perf_loaduse_o,
    output logic [CNT_W-1:0] perf_memstall_o,
    output logic [CNT_W-1:0] perf_flush_o
`endif
);

    localparam int WCNT_W = cnt_width(MEM_TIMEOUT);
    localparam logic [WCNT_W-1:0] TIMEOUT_CNT = WCNT_W'(MEM_TIMEOUT);

    stall_state_t      state_reg;
    logic [WCNT_W-1:0] wcnt_reg;
    logic              access;
    logic              freeze;

    assign access = EX_MEM_MemRead_i | EX_MEM_MemWrite_i;

    // Memory handshake FSM: the wait counter starts at 1 on entering WAIT, so
    // ERR follows exactly MEM_TIMEOUT ack-less WAIT cycles; an ack wins.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_reg <= IDLE;
            wcnt_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (access) begin
                        state_reg <= WAIT;
                        wcnt_reg  <= WCNT_W'(1);
                    end
                end
                WAIT: begin
                    if (mem_ack_i) begin
                        state_reg <= IDLE;
                    end else if (wcnt_reg >= TIMEOUT_CNT) begin
                        state_reg <= ERR;
                    end else begin
                        wcnt_reg <= wcnt_reg + 1'b1;
                    end
                end
                ERR: begin
                    state_reg <= ERR;
                end
                default: begin
                    state_reg <= IDLE;
                    wcnt_reg  <= '0;
                end
            endcase
        end
    end

    // Freeze and request decode from state; ack releases the pipe in the same cycle.
    always_comb begin
        freeze    = 1'b0;
        mem_req_o = 1'b0;
        case (state_reg)
            IDLE: begin
                freeze    = access;
                mem_req_o = access;
            end
            WAIT: begin
                freeze    = ~mem_ack_i;
                mem_req_o = 1'b1;
            end
            ERR: begin
                freeze    = 1'b1;
                mem_req_o = 1'b0;
            end
            default: begin
                freeze    = 1'b0;
                mem_req_o = 1'b0;
            end
        endcase
    end

    // Stage control: freeze beats load-use, which beats branch flush.
    // A branch coinciding with load-use is dropped; it re-resolves after the bubble.
    always_comb begin
        PC_Write_o     = 1'b1;
        IF_ID_Write_o  = 1'b1;
        EX_MEM_Write_o = 1'b1;
        MEM_WB_Write_o = 1'b1;
        IF_ID_Flush_o  = 1'b0;
        ID_EX_Flush_o  = 1'b0;
        if (freeze) begin
            PC_Write_o     = 1'b0;
            IF_ID_Write_o  = 1'b0;
            EX_MEM_Write_o = 1'b0;
            MEM_WB_Write_o = 1'b0;
        end else if (hazard_stall_i) begin
            PC_Write_o    = 1'b0;
            IF_ID_Write_o = 1'b0;
            ID_EX_Flush_o = 1'b1;
        end else if (branch_taken_i) begin
            IF_ID_Flush_o = 1'b1;
        end
    end

    assign mem_err_o = (state_reg == ERR);

`ifdef STALL_PERF_CNT_EN
    logic [2:0] perf_evt;

    assign perf_evt = {IF_ID_Flush_o, freeze, (~freeze) & hazard_stall_i};

    stall_perf_counters #(
        .CNT_W (CNT_W)
    ) u_perf (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .evt_i      (perf_evt),
        .loaduse_o  (perf_loaduse_o),
        .memstall_o (perf_memstall_o),
        .flush_o    (perf_flush_o)
    );
`else
    logic unused_cnt_w;
    assign unused_cnt_w = (CNT_W > 0);
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// Directed testbench for pipeline_stall_ctrl (MEM_TIMEOUT=4, CNT_W=2).
// Outputs are packed into one control word and compared against constants.
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic hazard = 1'b0, branch = 1'b0, rd = 1'b0, wr = 1'b0, ack = 1'b0;
    logic mem_req, pc_w, ifid_w, ifid_f, idex_f, exmem_w, memwb_w, mem_err;
`ifdef STALL_PERF_CNT_EN
    logic [1:0] perf_lu, perf_ms, perf_fl;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    // {mem_req, PC_W, IFID_W, IFID_F, IDEX_F, EXMEM_W, MEMWB_W, mem_err}
    logic [7:0] ctl;
    assign ctl = {mem_req, pc_w, ifid_w, ifid_f, idex_f, exmem_w, memwb_w, mem_err};

    localparam logic [7:0] C_NORMAL  = 8'b0110_0110;
    localparam logic [7:0] C_HAZARD  = 8'b0000_1110;
    localparam logic [7:0] C_BRANCH  = 8'b0111_0110;
    localparam logic [7:0] C_FREEZE  = 8'b1000_0000;
    localparam logic [7:0] C_ACK     = 8'b1110_0110;
    localparam logic [7:0] C_ACK_BR  = 8'b1111_0110;
    localparam logic [7:0] C_ACK_HZ  = 8'b1000_1110;
    localparam logic [7:0] C_ERR     = 8'b0000_0001;

    always #5 clk = ~clk;

    pipeline_stall_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (2)
    ) dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .hazard_stall_i    (hazard),
        .branch_taken_i    (branch),
        .EX_MEM_MemRead_i  (rd),
        .EX_MEM_MemWrite_i (wr),
        .mem_ack_i         (ack),
        .mem_req_o         (mem_req),
        .PC_Write_o        (pc_w),
        .IF_ID_Write_o     (ifid_w),
        .IF_ID_Flush_o     (ifid_f),
        .ID_EX_Flush_o     (idex_f),
        .EX_MEM_Write_o    (exmem_w),
        .MEM_WB_Write_o    (memwb_w),
        .mem_err_o         (mem_err)
`ifdef STALL_PERF_CNT_EN
        ,
        .perf_loaduse_o    (perf_lu),
        .perf_memstall_o   (perf_ms),
        .perf_flush_o      (perf_fl)
`endif
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %b expected %b", tag, got, exp);
        end else begin
            $display("ok   %s: %b", tag, got);
        end
    endtask

    // One cycle: apply inputs just after the edge, check mid-cycle, advance.
    task automatic vec(input string tag, input logic h, input logic b, input logic r,
                       input logic w, input logic a, input logic [7:0] exp);
        hazard = h; branch = b; rd = r; wr = w; ack = a;
        @(negedge clk);
        check_eq(tag, {24'd0, ctl}, {24'd0, exp});
        @(posedge clk);
        #1;
    endtask

    initial begin
        // Reset held two edges with idle inputs.
        rst = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset", {24'd0, ctl}, {24'd0, C_NORMAL});
        rst = 1'b1;

        vec("idle",          0, 0, 0, 0, 0, C_NORMAL);
        vec("hazard+branch", 1, 1, 0, 0, 0, C_HAZARD);
        vec("branch",        0, 1, 0, 0, 0, C_BRANCH);
        vec("hazard",        1, 0, 0, 0, 0, C_HAZARD);

        // Load with three ack-less WAIT cycles: four frozen cycles, then ack.
        vec("ld_idle",   0, 0, 1, 0, 0, C_FREEZE);
        vec("ld_wait1",  0, 0, 1, 0, 0, C_FREEZE);
        vec("ld_wait2",  0, 0, 1, 0, 0, C_FREEZE);
        vec("ld_wait3",  0, 0, 1, 0, 0, C_FREEZE);
        vec("ld_ack",    0, 0, 1, 0, 1, C_ACK);
        vec("ld_after",  0, 0, 0, 0, 0, C_NORMAL);

        // Back-to-back loads: second freeze right after the first ack.
        vec("b2b_req1",  0, 0, 1, 0, 0, C_FREEZE);
        vec("b2b_ack1",  0, 0, 1, 0, 1, C_ACK);
        vec("b2b_req2",  0, 0, 1, 0, 0, C_FREEZE);
        vec("b2b_ack2",  0, 0, 1, 0, 1, C_ACK);

        // Store with branch pending: flush suppressed until the ack cycle.
        vec("st_br_idle", 0, 1, 0, 1, 0, C_FREEZE);
        vec("st_br_wait", 0, 1, 0, 1, 0, C_FREEZE);
        vec("st_br_ack",  0, 1, 0, 1, 1, C_ACK_BR);

        // Load-use pending through a freeze takes effect at the ack.
        vec("ld_hz_idle", 1, 0, 1, 0, 0, C_FREEZE);
        vec("ld_hz_ack",  1, 0, 1, 0, 1, C_ACK_HZ);

        // Ack in IDLE is ignored: the access still freezes, a real WAIT follows.
        vec("idle_ack",   0, 0, 1, 0, 1, C_FREEZE);
        vec("idle_ack_w", 0, 0, 1, 0, 1, C_ACK);
        vec("idle_quiet", 0, 0, 0, 0, 0, C_NORMAL);

        // Timeout: four ack-less WAIT cycles then ERR.
        vec("to_idle",   0, 0, 1, 0, 0, C_FREEZE);
        vec("to_wait1",  0, 0, 1, 0, 0, C_FREEZE);
        vec("to_wait2",  0, 0, 1, 0, 0, C_FREEZE);
        vec("to_wait3",  0, 0, 1, 0, 0, C_FREEZE);
        vec("to_wait4",  0, 0, 1, 0, 0, C_FREEZE);
        vec("err",       0, 0, 1, 0, 0, C_ERR);
        vec("err_ack",   1, 1, 1, 0, 1, C_ERR);
        vec("err_quiet", 0, 1, 0, 0, 0, C_ERR);
        rst = 1'b0;
        vec("err_in_rst", 0, 0, 0, 0, 0, C_ERR);
        rst = 1'b1;
        vec("err_cleared", 0, 0, 0, 0, 0, C_NORMAL);

`ifdef STALL_PERF_CNT_EN
        // Counters from a fresh reset: 2 load-use, 3 freeze, 1 flush.
        rst = 1'b0;
        vec("perf_rst",  0, 0, 0, 0, 0, C_NORMAL);
        rst = 1'b1;
        vec("perf_hz1",  1, 0, 0, 0, 0, C_HAZARD);
        vec("perf_hz2",  1, 0, 0, 0, 0, C_HAZARD);
        vec("perf_ld0",  0, 0, 1, 0, 0, C_FREEZE);
        vec("perf_ld1",  0, 0, 1, 0, 0, C_FREEZE);
        vec("perf_ld2",  0, 0, 1, 0, 0, C_FREEZE);
        vec("perf_ack",  0, 0, 1, 0, 1, C_ACK);
        vec("perf_br1",  0, 1, 0, 0, 0, C_BRANCH);
        check_eq("perf_loaduse",  {30'd0, perf_lu}, 32'd2);
        check_eq("perf_memstall", {30'd0, perf_ms}, 32'd3);
        check_eq("perf_flush",    {30'd0, perf_fl}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            vec("perf_brx", 0, 1, 0, 0, 0, C_BRANCH);
        end
        check_eq("perf_flush_sat", {30'd0, perf_fl}, 32'd3);
`endif

        hazard = 0; branch = 0; rd = 0; wr = 0; ack = 0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
